mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word-address width (2^ADDR_W 32-bit words).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports if_req in 1 fetch request; if_addr in 32 byte address; if_gnt out 1 fetch accepted; if_rvalid out 1 fetch data valid; if_rdata out 32 fetch data.
REQ-005 SHALL have ports dm_req in 1 data request; dm_we in 1 write enable; dm_addr in 32 byte address; dm_wdata in 32 write data; dm_gnt out 1 data accepted; dm_rvalid out 1 read data valid; dm_rdata out 32 read data.
REQ-006 SHALL have RAM-side ports ram_en out 1; ram_we out 1; ram_addr out ADDR_W; ram_wdata out 32; ram_rdata in 32. RAM is single-port with synchronous read, 1-cycle latency.
REQ-007 SHALL have port stall_cnt  out 16  saturating count of refused-request cycles.

Function
REQ-008 SHALL issue at most one RAM access per cycle; ram_en = if_gnt | dm_gnt, with if_gnt and dm_gnt mutually exclusive.
REQ-009 SHALL compute if_gnt/dm_gnt combinationally in the request cycle; a requester holds req, addr, we and wdata stable until it samples its gnt high.
REQ-010 SHALL drive ram_addr = granted addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored (wrap-around, no error).
REQ-011 SHALL drive ram_we = dm_we & dm_gnt, ram_wdata = dm_wdata; fetch is always a read.
REQ-012 SHALL, with only one request asserted, grant it in that cycle.
REQ-013 SHALL, with both requests asserted, grant dm (fixed priority) unless MEM_ARB_RR_EN is defined (REQ-021).
REQ-014 SHALL keep a state register: IDLE (no read issued last cycle), RD_I (fetch read issued), RD_D (data read issued), WR (data write issued); next state set each cycle by the grant issued: none->IDLE, if_gnt->RD_I, dm_gnt & !dm_we->RD_D, dm_gnt & dm_we->WR.
REQ-015 SHALL assert if_rvalid for exactly the cycle in state RD_I and dm_rvalid for exactly the cycle in state RD_D; writes produce no rvalid.
REQ-016 SHALL drive if_rdata = ram_rdata when if_rvalid else 0; dm_rdata likewise.
REQ-017 SHALL support back-to-back grants every cycle; a new grant overlaps the previous read's rvalid cycle.
REQ-018 SHALL read old data on same-cycle write-after-read to the same word across consecutive cycles exactly as the RAM returns it (no forwarding).
REQ-019 SHALL increment stall_cnt by 1 in any cycle where a request is high and its gnt low (max +1 per cycle), saturating at 16'hFFFF.

Reset
REQ-020 SHALL, while rstn low, force state IDLE, stall_cnt 0, RR pointer to "IF last", and drive if_gnt, dm_gnt, ram_en, ram_we, if_rvalid, dm_rvalid low and rdata outputs 0; a read in flight at reset assertion is dropped, no rvalid after release.

Configuration
REQ-021 SHALL, with macro MEM_ARB_RR_EN defined, resolve contention round-robin: a 1-bit pointer records the last contended winner and the other requester wins next contention; pointer updates only on contended cycles. Without the macro: fixed dm priority, no pointer register.

Verification
REQ-022 SHALL cover: if_req=1 addr 0x10 alone, RAM word 4=0xDEADBEEF -> if_gnt same cycle, ram_addr=4, next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-023 SHALL cover: dm write addr 0x20 data 0x12345678 then dm read 0x20 next cycle -> ram_we pulse 1 cycle, then dm_rvalid with 0x12345678, no if_rvalid.
REQ-024 SHALL cover: if_req and dm_req both held 4 cycles (reads) -> fixed: dm_gnt all 4, stall_cnt=4; MEM_ARB_RR_EN: grants D,I,D,I, stall_cnt=4.
REQ-025 SHALL cover: rstn pulled low in cycle after fetch grant -> no if_rvalid, stall_cnt=0, all outputs 0 until release.
REQ-026 SHALL cover: if_addr 0x0000_0403 with ADDR_W=8 -> ram_addr=0x00 (wrap, low bits ignored); stall_cnt forced to 16'hFFFE plus 3 contended cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port synchronous-read RAM.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed data-port priority.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {StIdle, StRdI, StRdD, StWr} state_e;

   state_e      state_q, state_d;
   logic [15:0] stall_q, stall_d;

`ifdef MEM_ARB_RR_EN
   logic last_if_q, last_if_d;
`endif

   // Grants are gated by reset so nothing reaches the RAM while rstn is low
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (rstn) begin
         if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
            dm_gnt = last_if_q;
            if_gnt = !last_if_q;
`else
            dm_gnt = 1'b1;
`endif
         end else begin
            if_gnt = if_req;
            dm_gnt = dm_req;
         end
      end
   end

   assign ram_en    = if_gnt | dm_gnt;
   assign ram_we    = dm_we & dm_gnt;
   assign ram_wdata = dm_wdata;
   assign ram_addr  = dm_gnt ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               dm_addr[31:ADDR_W+2], dm_addr[1:0]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         stall_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Reset value "IF last" hands the first contention to the data port
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_if_q <= 1'b1;
      end else begin
         last_if_q <= last_if_d;
      end
   end

   always_comb begin
      last_if_d = last_if_q;
      if (if_req && dm_req) begin
         last_if_d = if_gnt;
      end
   end
`endif

   always_comb begin
      state_d = StIdle;
      if (if_gnt) begin
         state_d = StRdI;
      end else if (dm_gnt) begin
         state_d = dm_we ? StWr : StRdD;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (((if_req && !if_gnt) || (dm_req && !dm_gnt)) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_comb begin
      if_rvalid = (state_q == StRdI);
      dm_rvalid = (state_q == StRdD);
      if_rdata  = if_rvalid ? ram_rdata : 32'h0;
      dm_rdata  = dm_rvalid ? ram_rdata : 32'h0;
      stall_cnt = stall_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM and a read-data scoreboard.
// Honours MEM_ARB_RR_EN in its arbitration model.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 8;

   logic              clk;
   logic              rstn;
   logic              if_req, if_gnt, if_rvalid;
   logic [31:0]       if_addr, if_rdata;
   logic              dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [31:0]       dm_addr, dm_wdata, dm_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [15:0]       stall_cnt;

   mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM, synchronous read, read-old-data
   logic [31:0] ram [2**ADDR_W];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   typedef struct {
      bit          is_dm;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t     sb_q[$];
   logic [31:0] model_mem [2**ADDR_W];
   logic [15:0] exp_stall;
   bit          ptr_if_last;
   int          n_assert;
   int          n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, check grants against the model, clock, check read return
   task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input bit quiet);
      bit          eg_i, eg_d;
      logic [7:0]  ea;
      rd_exp_t     e;
      if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
      eg_i = 1'b0; eg_d = 1'b0;
      if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
         eg_d = ptr_if_last;
         eg_i = !ptr_if_last;
         ptr_if_last = eg_i;
`else
         eg_d = 1'b1;
`endif
      end else begin
         eg_i = ir;
         eg_d = dr;
      end
      ea = eg_d ? da[9:2] : ia[9:2];
      #1;
      if (!quiet) begin
         check("if_gnt", {31'd0, if_gnt}, {31'd0, eg_i});
         check("dm_gnt", {31'd0, dm_gnt}, {31'd0, eg_d});
         check("ram_en", {31'd0, ram_en}, {31'd0, eg_i | eg_d});
         check("ram_we", {31'd0, ram_we}, {31'd0, eg_d & dwe});
         if (eg_i || eg_d) check("ram_addr", {24'd0, ram_addr}, {24'd0, ea});
         if (eg_d && dwe) check("ram_wdata", ram_wdata, dwd);
      end
      if ((ir && !eg_i) || (dr && !eg_d)) begin
         if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
      if (eg_i) begin
         e.is_dm = 1'b0; e.data = model_mem[ea]; sb_q.push_back(e);
      end else if (eg_d && !dwe) begin
         e.is_dm = 1'b1; e.data = model_mem[ea]; sb_q.push_back(e);
      end else if (eg_d && dwe) begin
         model_mem[ea] = dwd;
      end
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (!quiet) begin
            check("if_rvalid", {31'd0, if_rvalid}, {31'd0, !e.is_dm});
            check("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, e.is_dm});
            check("if_rdata", if_rdata, e.is_dm ? 32'h0 : e.data);
            check("dm_rdata", dm_rdata, e.is_dm ? e.data : 32'h0);
         end
      end else if (!quiet) begin
         check("if_rvalid_idle", {31'd0, if_rvalid}, 32'h0);
         check("dm_rvalid_idle", {31'd0, dm_rvalid}, 32'h0);
         check("if_rdata_idle", if_rdata, 32'h0);
         check("dm_rdata_idle", dm_rdata, 32'h0);
      end
      if (!quiet) check("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      int guard;
      n_assert = 0; n_fail = 0; exp_stall = 16'h0; ptr_if_last = 1'b1;
      for (int i = 0; i < 2**ADDR_W; i++) begin
         ram[i] = 32'h0; model_mem[i] = 32'h0;
      end
      ram[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
      ram_rdata = 32'h0;
      rstn = 1'b0;
      if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 32'h0; dm_wdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_if_rvalid", {31'd0, if_rvalid}, 32'h0);
      check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'h0);
      check("rst_ram_en", {31'd0, ram_en}, 32'h0);
      check("rst_stall", {16'd0, stall_cnt}, 32'h0);
      rstn = 1'b1;

      // Lone fetch of word 4
      step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      idle();

      // Write then read back the same word
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      idle();

      // Four cycles of contention
      for (int i = 0; i < 4; i++) step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      idle();
      check("stall_after_contention", {16'd0, stall_cnt}, 32'd4);

      // Address wrap: bits above ADDR_W+1 and byte offset ignored
      step(1'b1, 32'h0000_0403, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      idle();

      // Drive the counter up to its last step below saturation
      guard = 0;
      while (exp_stall != 16'hFFFE && guard < 70000) begin
         step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
         guard++;
      end
      idle();
      check("stall_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      idle();
      check("stall_saturated", {16'd0, stall_cnt}, 32'h0000_FFFF);

      // Reset asserted in the cycle after a fetch grant drops its rvalid
      step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      rstn = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
      sb_q.delete();
      exp_stall = 16'h0;
      ptr_if_last = 1'b1;
      #1;
      check("rstin_if_rvalid", {31'd0, if_rvalid}, 32'h0);
      check("rstin_if_rdata", if_rdata, 32'h0);
      check("rstin_if_gnt", {31'd0, if_gnt}, 32'h0);
      check("rstin_dm_gnt", {31'd0, dm_gnt}, 32'h0);
      check("rstin_ram_en", {31'd0, ram_en}, 32'h0);
      check("rstin_ram_we", {31'd0, ram_we}, 32'h0);
      check("rstin_stall", {16'd0, stall_cnt}, 32'h0);
      @(posedge clk); #1;
      check("rstin_stall_hold", {16'd0, stall_cnt}, 32'h0);
      check("rstin_dm_rvalid", {31'd0, dm_rvalid}, 32'h0);
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      rstn = 1'b1;
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
